// File: rtl/matmul_operand_sequencer.sv
// Operand store and run sequencer for the 3x3 MAC-array matrix multiplier.
// A start runs one clear cycle, three accumulate cycles (k = 0..2) and an
// unload window of UNLOAD_CYCLES, then pulses done.
// Optional build macro MATSEQ_PINGPONG_EN: two operand banks so the next
// matrix pair can be written while a run is in progress.
module matmul_operand_sequencer #(
  parameter int DW            = 4,
  parameter int UNLOAD_CYCLES = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic [DW-1:0] data_w1,
  output logic [DW-1:0] data_w2,
  output logic [DW-1:0] data_w3,
  output logic [DW-1:0] data_x1,
  output logic [DW-1:0] data_x2,
  output logic [DW-1:0] data_x3,
  output logic [8:0]    load,
  output logic [8:0]    clear,
  output logic          unload_res
);

  localparam int CNTW = (UNLOAD_CYCLES > 1) ? $clog2(UNLOAD_CYCLES) : 1;
  localparam logic [CNTW-1:0] LAST_UNLD = CNTW'(UNLOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_UNLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] unldCnt_q, unldCnt_d;

  // Matrix view used by the current run, row-major r*3+c
  logic [8:0][DW-1:0] rdW, rdX;

  logic wrValid;
  logic errDrop;
  logic startAccept;

  assign wrValid     = wr_en && (wr_addr <= 4'd8);
  assign startAccept = (state_q == S_IDLE) && start;

`ifdef MATSEQ_PINGPONG_EN
  logic [1:0][8:0][DW-1:0] wMem_q, xMem_q;
  logic                    act_q;

  // Writes always fill the idle bank; starting a run flips which bank is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wMem_q <= '0;
      xMem_q <= '0;
      act_q  <= 1'b0;
    end else begin
      if (startAccept) begin
        act_q <= ~act_q;
      end
      if (wrValid) begin
        if (wr_sel) begin
          xMem_q[~act_q][wr_addr] <= wr_data;
        end else begin
          wMem_q[~act_q][wr_addr] <= wr_data;
        end
      end
    end
  end

  assign rdW     = wMem_q[act_q];
  assign rdX     = xMem_q[act_q];
  assign errDrop = 1'b0;
`else
  logic [8:0][DW-1:0] wMem_q, xMem_q;
  logic               wrAccept;

  assign wrAccept = wrValid && (state_q == S_IDLE);
  assign errDrop  = wrValid && (state_q != S_IDLE);

  // Single bank: operands may only change while no run is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wMem_q <= '0;
      xMem_q <= '0;
    end else if (wrAccept) begin
      if (wr_sel) begin
        xMem_q[wr_addr] <= wr_data;
      end else begin
        wMem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign rdW = wMem_q;
  assign rdX = xMem_q;
`endif

  // Next-state and unload counter sequencing
  always_comb begin
    state_d   = state_q;
    unldCnt_d = unldCnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR:  state_d = S_MAC0;
      S_MAC0: state_d = S_MAC1;
      S_MAC1: state_d = S_MAC2;
      S_MAC2: begin
        state_d   = S_UNLD;
        unldCnt_d = '0;
      end
      S_UNLD: begin
        if (unldCnt_q == LAST_UNLD) begin
          state_d = S_DONE;
        end else begin
          unldCnt_d = unldCnt_q + CNTW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Column k of W and row k of X for the accumulate state being entered
  logic [DW-1:0] colW1, colW2, colW3, colX1, colX2, colX3;

  always_comb begin
    colW1 = '0;
    colW2 = '0;
    colW3 = '0;
    colX1 = '0;
    colX2 = '0;
    colX3 = '0;
    case (state_d)
      S_MAC0: begin
        colW1 = rdW[0]; colW2 = rdW[3]; colW3 = rdW[6];
        colX1 = rdX[0]; colX2 = rdX[1]; colX3 = rdX[2];
      end
      S_MAC1: begin
        colW1 = rdW[1]; colW2 = rdW[4]; colW3 = rdW[7];
        colX1 = rdX[3]; colX2 = rdX[4]; colX3 = rdX[5];
      end
      S_MAC2: begin
        colW1 = rdW[2]; colW2 = rdW[5]; colW3 = rdW[8];
        colX1 = rdX[6]; colX2 = rdX[7]; colX3 = rdX[8];
      end
      default: ;
    endcase
  end

  logic          busy_q, done_q, wrErr_q, unload_q;
  logic [8:0]    load_q, clear_q;
  logic [DW-1:0] dw1_q, dw2_q, dw3_q, dx1_q, dx2_q, dx3_q;

  // State register with outputs registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      unldCnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrErr_q   <= 1'b0;
      unload_q  <= 1'b0;
      load_q    <= '0;
      clear_q   <= '0;
      dw1_q     <= '0;
      dw2_q     <= '0;
      dw3_q     <= '0;
      dx1_q     <= '0;
      dx2_q     <= '0;
      dx3_q     <= '0;
    end else begin
      state_q   <= state_d;
      unldCnt_q <= unldCnt_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      wrErr_q   <= errDrop;
      unload_q  <= (state_d == S_UNLD);
      clear_q   <= (state_d == S_CLR) ? 9'h1FF : 9'h000;
      load_q    <= ((state_d == S_MAC0) || (state_d == S_MAC1) || (state_d == S_MAC2))
                   ? 9'h1FF : 9'h000;
      dw1_q     <= colW1;
      dw2_q     <= colW2;
      dw3_q     <= colW3;
      dx1_q     <= colX1;
      dx2_q     <= colX2;
      dx3_q     <= colX3;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_err     = wrErr_q;
  assign unload_res = unload_q;
  assign load       = load_q;
  assign clear      = clear_q;
  assign data_w1    = dw1_q;
  assign data_w2    = dw2_q;
  assign data_w3    = dw3_q;
  assign data_x1    = dx1_q;
  assign data_x2    = dx2_q;
  assign data_x3    = dx3_q;

endmodule
